// File: rtl/store_buffer_pkg.sv
// Shared widths, drain FSM encoding and entry layout for the store buffer.
package store_buffer_pkg;
    localparam int SB_DEPTH_DEF = 4;
    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int PTAG_W       = 6;

    typedef enum logic {
        SB_IDLE  = 1'b0,
        SB_WRITE = 1'b1
    } sb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

    // Loads and stores are compared at word granularity.
    function automatic logic word_match(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return a[ADDR_W-1:2] == b[ADDR_W-1:2];
    endfunction
endpackage

// File: rtl/store_buffer_if.sv
// Store buffer bus bundle: ROB commit, register-file read, cache write and load probe.
interface store_buffer_if import store_buffer_pkg::*; ();
    logic              Rob_CommitMemWrite;
    logic [ADDR_W-1:0] Rob_SwAddr;
    logic [PTAG_W-1:0] Rob_CommitCurrPhyAddr;
    logic [PTAG_W-1:0] SB_RfRdAddr;
    logic [DATA_W-1:0] Rf_SbData;
    logic              SB_Full;
    logic              SB_DceWrite;
    logic [ADDR_W-1:0] SB_DceAddr;
    logic [DATA_W-1:0] SB_DceData;
    logic              Dce_WriteDone;
    logic [ADDR_W-1:0] Lsq_LoadAddr;
    logic              SB_AddrMatch;

    // CPU side: ROB, register file, data cache and LSQ.
    modport master (
        output Rob_CommitMemWrite, Rob_SwAddr, Rob_CommitCurrPhyAddr, Rf_SbData,
               Dce_WriteDone, Lsq_LoadAddr,
        input  SB_RfRdAddr, SB_Full, SB_DceWrite, SB_DceAddr, SB_DceData, SB_AddrMatch
    );

    modport slave (
        input  Rob_CommitMemWrite, Rob_SwAddr, Rob_CommitCurrPhyAddr, Rf_SbData,
               Dce_WriteDone, Lsq_LoadAddr,
        output SB_RfRdAddr, SB_Full, SB_DceWrite, SB_DceAddr, SB_DceData, SB_AddrMatch
    );
endinterface

// File: rtl/store_buffer.sv
// Committed-store FIFO drained to the data cache one entry at a time, with a
// word-address match against issuing loads.
module store_buffer import store_buffer_pkg::*; #(
    parameter int SB_DEPTH = SB_DEPTH_DEF
) (
    input  logic           Clk,
    input  logic           Resetb,
    store_buffer_if.slave  sb
);
    localparam int IW = $clog2(SB_DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] count;
    sb_state_e     state_q;
    sb_entry_t     mem_q [SB_DEPTH];
    sb_entry_t     head;
    logic          empty, full, push, pop, match;

    assign empty = rd_ptr_q == wr_ptr_q;
    assign full  = (rd_ptr_q[IW-1:0] == wr_ptr_q[IW-1:0]) && (rd_ptr_q[IW] != wr_ptr_q[IW]);
    assign count = wr_ptr_q - rd_ptr_q;

    assign push = sb.Rob_CommitMemWrite && !full;
    assign pop  = (state_q == SB_WRITE) && sb.Dce_WriteDone;

    assign wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            state_q  <= SB_IDLE;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            case (state_q)
                SB_IDLE:  if (!empty) state_q <= SB_WRITE;
                // A same-edge push keeps the drain going without an IDLE bubble.
                SB_WRITE: if (pop && (rd_ptr_d == wr_ptr_d)) state_q <= SB_IDLE;
                default:  state_q <= SB_IDLE;
            endcase
        end
    end

    // Entry storage is not reset; pointers alone define occupancy.
    always_ff @(posedge Clk) begin
        if (push) mem_q[wr_ptr_q[IW-1:0]] <= '{addr: sb.Rob_SwAddr, data: sb.Rf_SbData};
    end

    always_comb begin
        logic [IW-1:0] off;
        match = 1'b0;
        off   = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            off = IW'(i) - rd_ptr_q[IW-1:0];
            if (({1'b0, off} < count) && word_match(mem_q[i].addr, sb.Lsq_LoadAddr))
                match = 1'b1;
        end
    end

    assign head            = mem_q[rd_ptr_q[IW-1:0]];
    assign sb.SB_RfRdAddr  = sb.Rob_CommitCurrPhyAddr;
    assign sb.SB_Full      = full;
    assign sb.SB_DceWrite  = state_q == SB_WRITE;
    assign sb.SB_DceAddr   = head.addr;
    assign sb.SB_DceData   = head.data;
    assign sb.SB_AddrMatch = match;

`ifndef SYNTHESIS
    // The ROB must hold its store while SB_Full is up; such a commit is dropped.
    always @(posedge Clk) begin
        if (Resetb && sb.Rob_CommitMemWrite)
            assert (!full) else $warning("store_buffer: commit while full dropped");
    end
`endif
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter SB_DEPTH, default 4, number of committed-store entries (power of two, 2..16).
REQ-002 SHALL have port Clk, input, 1, single clock; all state changes on rising edge.
REQ-003 SHALL have port Resetb, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port Rob_CommitMemWrite, input, 1, ROB is committing a store this cycle.
REQ-005 SHALL have port Rob_SwAddr, input, 32, byte address of the committing store.
REQ-006 SHALL have port Rob_CommitCurrPhyAddr, input, 6, physical tag of the committing store's rt.
REQ-007 SHALL have port SB_RfRdAddr, output, 6, register-file read address for store data.
REQ-008 SHALL have port Rf_SbData, input, 32, combinational register-file read data for SB_RfRdAddr.
REQ-009 SHALL have port SB_Full, output, 1, no free entry; ROB withholds store commit.
REQ-010 SHALL have port SB_DceWrite, output, 1, write request to the data cache.
REQ-011 SHALL have port SB_DceAddr, output, 32, head entry address.
REQ-012 SHALL have port SB_DceData, output, 32, head entry data.
REQ-013 SHALL have port Dce_WriteDone, input, 1, cache accepted the current write.
REQ-014 SHALL have port Lsq_LoadAddr, input, 32, address of a load requesting issue.
REQ-015 SHALL have port SB_AddrMatch, output, 1, a valid entry matches Lsq_LoadAddr.

Function
REQ-016 SHALL be a circular FIFO with rd_ptr and wr_ptr each log2(SB_DEPTH)+1 bits; MSB is the wrap bit.
REQ-017 SHALL define empty as rd_ptr==wr_ptr and full as equal low bits with differing MSB.
REQ-018 SHALL drive SB_RfRdAddr = Rob_CommitCurrPhyAddr combinationally at all times.
REQ-019 SHALL, on an edge with Rob_CommitMemWrite=1, write {Rob_SwAddr, Rf_SbData} to entry wr_ptr and increment wr_ptr modulo 2*SB_DEPTH.
REQ-020 SHALL derive SB_Full from registered pointers only, with no path from Rob_CommitMemWrite or Dce_WriteDone, to avoid a loop through the ROB commit logic.
REQ-021 SHALL ignore Rob_CommitMemWrite while full, with no pointer or entry change; this is a protocol violation flagged by an assertion.
REQ-022 SHALL run a drain FSM with states IDLE and WRITE.
REQ-023 SHALL transition IDLE->WRITE at the edge where the buffer is non-empty.
REQ-024 SHALL, in WRITE, assert SB_DceWrite and hold SB_DceAddr/SB_DceData at the head entry until Dce_WriteDone=1.
REQ-025 SHALL, in WRITE with Dce_WriteDone=1, increment rd_ptr; the FSM stays in WRITE if entries remain after the pop, else returns to IDLE.
REQ-026 SHALL ignore Dce_WriteDone in IDLE.
REQ-027 SHALL, when push and pop occur on the same edge, perform both; occupancy is unchanged.
REQ-028 SHALL accept a push into a full buffer on the edge it pops only on the next cycle, since SB_Full stays 1 during the popping cycle.
REQ-029 SHALL assert SB_AddrMatch combinationally when any occupied entry, including the one being drained, has addr[31:2]==Lsq_LoadAddr[31:2]; it is 0 when empty.
REQ-030 SHALL hold the data of committed stores through any pipeline flush; the buffer has no flush input.

Reset
REQ-031 SHALL, while Resetb=0, clear rd_ptr and wr_ptr, set the FSM to IDLE, and drive SB_Full=0, SB_DceWrite=0, SB_AddrMatch=0.
REQ-032 SHALL leave entry storage unreset; SB_DceAddr and SB_DceData are don't-care when SB_DceWrite=0.
REQ-033 SHALL discard an in-flight write and all entries when reset asserts mid-drain; reset release restarts from empty.

Structure
REQ-034 SHALL take SB_DEPTH, the FSM state encoding, and the 32-bit address/data width constants from the shared CPU package.
REQ-035 SHALL be a single module; the FIFO storage, drain FSM and address comparator stay inline, with no sub-module.

Verification
REQ-036 SHALL cover single store: commit addr 0x0000_0010, data 0xDEAD_BEEF -> SB_DceWrite=1 with that addr/data one cycle later; Dce_WriteDone=1 -> buffer empty, FSM IDLE.
REQ-037 SHALL cover fill: 4 commits with Dce_WriteDone held 0 -> SB_Full=1 after the 4th edge; a 5th commit attempt triggers the assertion and state is unchanged.
REQ-038 SHALL cover simultaneous push/pop: 2 entries held, commit and Dce_WriteDone on the same edge -> occupancy stays 2 and FIFO order is preserved.
REQ-039 SHALL cover wrap: 10 stores drained back-to-back -> pointers wrap and all 10 addr/data pairs appear in commit order with no IDLE bubble between them.
REQ-040 SHALL cover load match: entry at 0x0000_0104 -> Lsq_LoadAddr 0x0000_0106 gives SB_AddrMatch=1; 0x0000_0108 gives 0; after the entry drains, 0x0000_0106 gives 0.
REQ-041 SHALL cover reset mid-drain: Resetb pulsed low during WRITE -> SB_DceWrite=0 immediately, SB_Full=0, and the buffer is empty after release.
